// File: rtl/log_pkg.sv
// Shared definitions for the sensor logging path: word width, header tag and
// the feeder state encoding.
package log_pkg;

  localparam int         LOG_WORD_W = 16;
  localparam logic [7:0] HDR_TAG    = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_HDR,
    ST_ISSUE_DAT,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } feeder_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; the caller guarantees no push when full without
// a simultaneous pop, and no pop when empty.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);

endmodule

// File: rtl/sample_log_feeder.sv
// Buffers sensor samples and feeds them, framed by a header word every
// FRAME_LEN samples, to the SD SPI writer one word per start/busy handshake.
module sample_log_feeder
  import log_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FRAME_LEN   = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [LOG_WORD_W-1:0]   sample_data,
  input  logic                    wr_busy,
  output logic                    wr_start,
  output logic [LOG_WORD_W-1:0]   wr_data,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic                    ack_error
);

  // ACK_TIMEOUT must be at least 2; the counter only has to reach ACK_TIMEOUT-2.
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  feeder_state_t         r_state, w_state_next;
  logic [7:0]            r_frame_cnt, w_frame_cnt_next;
  logic [7:0]            r_word_cnt, w_word_cnt_next;
  logic                  r_hdr_flag, w_hdr_flag_next;
  logic [TW-1:0]         r_to_cnt, w_to_cnt_next;
  logic                  r_wr_start, w_wr_start_next;
  logic [LOG_WORD_W-1:0] r_wr_data, w_wr_data_next;
  logic                  r_ack_error, w_ack_error_next;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [LOG_WORD_W-1:0] w_head;

  // A full FIFO still accepts a sample when a data word leaves in the same cycle.
  assign w_pop  = (r_state == ST_ISSUE_DAT);
  assign w_push = sample_valid && (!w_full || w_pop);

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LOG_WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (sample_data),
    .dout  (w_head),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // wr_start/wr_data are loaded on entry to an ISSUE state so they are
  // registered and wr_data stays put for the whole handshake.
  always_comb begin
    w_state_next     = r_state;
    w_frame_cnt_next = r_frame_cnt;
    w_word_cnt_next  = r_word_cnt;
    w_hdr_flag_next  = r_hdr_flag;
    w_to_cnt_next    = r_to_cnt;
    w_wr_start_next  = 1'b0;
    w_wr_data_next   = r_wr_data;
    w_ack_error_next = r_ack_error;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_wr_start_next = 1'b1;
          if (r_word_cnt == 8'd0) begin
            w_state_next   = ST_ISSUE_HDR;
            w_wr_data_next = {HDR_TAG, r_frame_cnt};
          end else begin
            w_state_next   = ST_ISSUE_DAT;
            w_wr_data_next = w_head;
          end
        end
      end
      ST_ISSUE_HDR: begin
        w_frame_cnt_next = r_frame_cnt + 8'd1;
        w_hdr_flag_next  = 1'b1;
        w_to_cnt_next    = '0;
        w_state_next     = ST_WAIT_ACK;
      end
      ST_ISSUE_DAT: begin
        w_word_cnt_next = (r_word_cnt == 8'(FRAME_LEN - 1)) ? 8'd0 : r_word_cnt + 8'd1;
        w_hdr_flag_next = 1'b0;
        w_to_cnt_next   = '0;
        w_state_next    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (wr_busy) begin
          w_state_next = ST_WAIT_DONE;
        end else if (r_to_cnt == TW'(ACK_TIMEOUT - 2)) begin
          w_ack_error_next = 1'b1;
          w_state_next     = ST_IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!wr_busy) begin
          if (r_hdr_flag) begin
            w_state_next    = ST_ISSUE_DAT;
            w_wr_start_next = 1'b1;
            w_wr_data_next  = w_head;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= 8'd0;
      r_word_cnt  <= 8'd0;
      r_hdr_flag  <= 1'b0;
      r_to_cnt    <= '0;
      r_wr_start  <= 1'b0;
      r_wr_data   <= '0;
      r_ack_error <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_word_cnt  <= w_word_cnt_next;
      r_hdr_flag  <= w_hdr_flag_next;
      r_to_cnt    <= w_to_cnt_next;
      r_wr_start  <= w_wr_start_next;
      r_wr_data   <= w_wr_data_next;
      r_ack_error <= w_ack_error_next;
      if (sample_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign wr_start  = r_wr_start;
  assign wr_data   = r_wr_data;
  assign overflow  = r_overflow;
  assign ack_error = r_ack_error;

endmodule

// File: tb/tb_sample_log_feeder.sv
// Random-stimulus bench for sample_log_feeder: a queue-based model of the
// framed word stream plus a configurable writer responding to wr_start.
module tb_sample_log_feeder;

  localparam int DEPTH       = 16;
  localparam int FRAME_LEN   = 8;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        wr_busy;
  logic        wr_start;
  logic [15:0] wr_data;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        ack_error;

  sample_log_feeder #(
    .DEPTH       (DEPTH),
    .FRAME_LEN   (FRAME_LEN),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .wr_busy      (wr_busy),
    .wr_start     (wr_start),
    .wr_data      (wr_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .ack_error    (ack_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Writer: busy rises the cycle after start and stays high busy_len cycles.
  int   busy_len   = 64;
  logic wr_release = 1'b0;

  initial begin
    logic s;
    int   rem;
    rem     = 0;
    wr_busy = 1'b0;
    forever begin
      @(negedge clk);
      s = wr_start;
      @(posedge clk);
      #1;
      if (s === 1'b1) rem = busy_len;
      if (wr_release) rem = 0;
      if (rem > 0) begin
        wr_busy = 1'b1;
        rem--;
      end else begin
        wr_busy = 1'b0;
      end
    end
  end

  // Reference model: the issued stream is a header {A5,frame} before every
  // FRAME_LEN-th accepted sample, then the samples in arrival order.
  logic [15:0] m_q[$];
  logic [15:0] obs[$];
  int          m_level, m_data_sent, m_ack_k, start_cnt;
  logic [7:0]  m_frame;
  logic        m_ovf, m_ackerr, m_armed, m_last_hdr, m_xfer, m_busy_seen, prev_start;
  logic [15:0] m_last_word, exp_w;
  logic        next_is_hdr, pop_now, acc;

  always @(negedge clk) begin
    if (rst) begin
      m_q.delete();
      obs.delete();
      m_level = 0; m_data_sent = 0; m_ack_k = 0; start_cnt = 0; m_frame = 8'd0;
      m_ovf = 0; m_ackerr = 0; m_armed = 0; m_last_hdr = 0; m_xfer = 0;
      m_busy_seen = 0; prev_start = 0; m_last_word = 16'd0;
    end else begin
      check("level", 32'(fifo_level), 32'(m_level));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("ack_error", 32'(ack_error), 32'(m_ackerr));
      if (m_xfer && !wr_start) check("hold", 32'(wr_data), 32'(m_last_word));
      if (m_xfer) begin
        if (wr_busy) begin
          m_busy_seen = 1;
        end else if (m_busy_seen) begin
          m_xfer = 0;
        end else begin
          m_ack_k++;
          if (m_ack_k == ACK_TIMEOUT - 1) begin
            m_xfer   = 0;
            m_ackerr = 1;
            if (m_last_hdr) m_armed = 0;
          end
        end
      end
      pop_now = 0;
      if (wr_start) begin
        start_cnt++;
        obs.push_back(wr_data);
        check("start_gap", 32'(prev_start), 32'd0);
        check("no_overlap", 32'(m_xfer), 32'd0);
        next_is_hdr = ((m_data_sent % FRAME_LEN) == 0) && !m_armed;
        if (next_is_hdr) begin
          exp_w = {8'hA5, m_frame};
          m_frame++;
          m_armed = 1;
          m_last_hdr = 1;
        end else begin
          check("data_avail", 32'(m_q.size() > 0), 32'd1);
          exp_w = (m_q.size() > 0) ? m_q.pop_front() : 16'd0;
          m_data_sent++;
          m_armed = 0;
          m_last_hdr = 0;
          pop_now = 1;
        end
        check("word", 32'(wr_data), 32'(exp_w));
        m_last_word = exp_w;
        m_xfer = 1;
        m_busy_seen = 0;
        m_ack_k = 0;
      end
      acc = sample_valid && ((m_level < DEPTH) || pop_now);
      if (acc) m_q.push_back(sample_data);
      if (sample_valid && !acc) m_ovf = 1;
      m_level = m_level + (acc ? 1 : 0) - (pop_now ? 1 : 0);
      prev_start = wr_start;
    end
  end

  task automatic push(input logic [15:0] d);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample_data  = d;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_obs(input string tag, input int n, input int max_cyc);
    int i;
    i = 0;
    while (obs.size() < n && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(obs.size() >= n), 32'd1);
  endtask

  task automatic wait_busy_low();
    int i;
    i = 0;
    @(negedge clk);
    while (wr_busy && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("busy_low", 32'(wr_busy), 32'd0);
  endtask

  task automatic wait_start(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (!wr_start && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(wr_start), 32'd1);
  endtask

  logic [15:0] s_vals[20];
  logic [15:0] extra;

  initial begin
    logic pb, got;
    rst = 1'b1; sample_valid = 1'b0; sample_data = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and quiet idle
    repeat (20) @(negedge clk);
    check("rst_start_cnt", 32'(start_cnt), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ackerr", 32'(ack_error), 32'd0);

    // First-word latency and basic framing
    busy_len = 64;
    @(posedge clk); #1;
    sample_valid = 1'b1; sample_data = 16'h1234;
    @(negedge clk); check("lat_n", 32'(wr_start), 32'd0);
    @(posedge clk); #1 sample_valid = 1'b0;
    @(negedge clk); check("lat_n1", 32'(wr_start), 32'd0);
    @(negedge clk); check("lat_n2", 32'(wr_start), 32'd1);
    check("lat_hdr", 32'(wr_data), 32'hA500);
    for (int i = 0; i < 9; i++) begin
      push(16'($urandom));
      repeat (3) @(posedge clk);
    end
    wait_obs("basic_wait", 11, 3000);
    check("basic_hdr0", 32'(obs[0]), 32'hA500);
    check("basic_d0", 32'(obs[1]), 32'h1234);
    check("basic_hdr1", 32'(obs[9]), 32'hA501);
    reset_dut();
    wait_busy_low();

    // Overflow with writer held busy
    busy_len = 100000;
    for (int i = 0; i < 20; i++) begin
      s_vals[i] = 16'($urandom);
      @(posedge clk); #1;
      sample_valid = 1'b1; sample_data = s_vals[i];
    end
    @(posedge clk); #1 sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);

    // Release the writer; push exactly on the ISSUE_DAT pop cycle
    busy_len = 3; wr_release = 1'b1;
    wait_busy_low();
    wr_release = 1'b0;
    extra = 16'($urandom);
    @(posedge clk); #1;
    sample_valid = 1'b1; sample_data = extra;
    @(negedge clk); check("fullpop_start", 32'(wr_start), 32'd1);
    @(posedge clk); #1 sample_valid = 1'b0;
    @(negedge clk);
    check("fullpop_level", 32'(fifo_level), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd1);
    wait_obs("drain_wait", 20, 3000);
    check("drain_first", 32'(obs[1]), 32'(s_vals[0]));
    check("drain_16th", 32'(obs[17]), 32'(s_vals[15]));
    check("drain_extra", 32'(obs[19]), 32'(extra));
    repeat (20) @(negedge clk);
    check("drain_level", 32'(fifo_level), 32'd0);
    reset_dut();
    wait_busy_low();

    // Ack timeout: writer never answers
    busy_len = 0;
    push(16'hBEEF);
    wait_start("to_start");
    repeat (ACK_TIMEOUT - 1) @(negedge clk);
    check("to_before", 32'(ack_error), 32'd0);
    @(negedge clk);
    check("to_at", 32'(ack_error), 32'd1);
    check("to_idle", 32'(wr_start), 32'd0);
    @(negedge clk);
    check("to_reissue", 32'(wr_start), 32'd1);
    check("to_reissue_hdr", 32'(wr_data), 32'hA501);
    reset_dut();

    // 256 frames: frame counter wraps back to 0
    busy_len = 2;
    for (int i = 0; i < 256 * FRAME_LEN + 1; i++) begin
      push(16'($urandom));
      repeat (6) @(posedge clk);
    end
    wait_obs("wrap_wait", 256 * (FRAME_LEN + 1) + 1, 5000);
    check("wrap_hdr255", 32'(obs[255 * (FRAME_LEN + 1)]), 32'hA5FF);
    check("wrap_hdr256", 32'(obs[256 * (FRAME_LEN + 1)]), 32'hA500);

    // Reset while waiting for the writer to finish
    busy_len = 10;
    for (int i = 0; i < 5; i++) push(16'($urandom));
    pb = 1'b0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (wr_busy && pb) got = 1'b1;
      pb = wr_busy;
    end
    check("reach_wait_done", 32'(got), 32'd1);
    reset_dut();
    wait_busy_low();
    busy_len = 3;
    push(16'($urandom));
    push(16'($urandom));
    wait_obs("post_rst_wait", 3, 500);
    check("post_rst_hdr", 32'(obs[0]), 32'hA500);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sample_log_feeder.md
# sample_log_feeder

Upstream stage of the SPI data logger. It buffers 16-bit sensor samples in a small FIFO, inserts a framing header word every FRAME_LEN samples, and issues them one word at a time to `sd_spi_writer` through that block's `start`/`data_in`/`busy` handshake. Samples that arrive while the FIFO is full are dropped and flagged, so the sensor side never stalls.

## Interface
- `DEPTH`, 16: FIFO depth in words; must be a power of two, at least 2.
- `FRAME_LEN`, 8: number of data words per frame, from 1 to 255.
- `ACK_TIMEOUT`, 16: cycles to wait for `wr_busy` to rise after `wr_start`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  one-cycle strobe; `sample_data` is valid in this cycle.
- `sample_data`  in  16  sensor sample.
- `wr_busy`  in  1  `busy` from `sd_spi_writer`.
- `wr_start`  out  1  one-cycle pulse to the writer `start`.
- `wr_data`  out  16  word to the writer `data_in`.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: at least one sample was dropped.
- `ack_error`  out  1  sticky: the writer did not acknowledge a start.

## Operation
- **FIFO push:** accepted when `sample_valid` is high and either level < DEPTH or a pop happens in the same cycle. Otherwise the sample is dropped and `overflow` is set.
- **FIFO pop:** occurs only on the cycle a data word is issued (the `ISSUE_DAT` state).
- **State machine states:** IDLE, ISSUE_HDR, ISSUE_DAT, WAIT_ACK, WAIT_DONE.
- **IDLE:**
  - If the FIFO is non-empty and `word_cnt` == 0, go to ISSUE_HDR.
  - If the FIFO is non-empty and `word_cnt` != 0, go to ISSUE_DAT.
  - If the FIFO is empty, stay in IDLE.
- **ISSUE_HDR:**
  - Drive `wr_start` = 1 and `wr_data` = {8'hA5, `frame_cnt`}.
  - `frame_cnt` increments and wraps 255 -> 0.
  - Go to WAIT_ACK with `hdr_flag` set.
- **ISSUE_DAT:**
  - Drive `wr_start` = 1 and `wr_data` = FIFO head, then pop.
  - `word_cnt` increments; it wraps FRAME_LEN-1 -> 0.
  - Go to WAIT_ACK with `hdr_flag` clear.
- **WAIT_ACK:**
  - When `wr_busy` == 1, go to WAIT_DONE.
  - After ACK_TIMEOUT cycles without `wr_busy`, set `ack_error` and go to IDLE. The word counts as sent.
- **WAIT_DONE:**
  - When `wr_busy` == 0:
    - If `hdr_flag` is set, go directly to ISSUE_DAT. The FIFO is guaranteed non-empty because the header is only issued when the FIFO is non-empty.
    - Otherwise, go to IDLE.
- **Hold rule:** `wr_data` stays constant from the `wr_start` cycle until the transfer completes or times out.
- **Stickiness:** `overflow` and `ack_error` clear only on `rst`.

## Timing
- **Reset values:** `wr_start` 0, `wr_data` 0, `fifo_level` 0, `overflow` 0, `ack_error` 0, `frame_cnt` 0, `word_cnt` 0, state IDLE, FIFO empty.
- **Registered outputs:** all outputs are registered.
- **`fifo_level` update:** reflects a push or pop in the cycle after it.
- **First-word latency:** with the block idle and the FIFO empty, `sample_valid` in cycle N makes the header `wr_start` high in cycle N+2.
- **Pipeline after header:** the first data `wr_start` is high 1 cycle after `wr_busy` is seen low in WAIT_DONE.
- **Start spacing:** at least 2 cycles between consecutive `wr_start` pulses. `wr_start` is never high for 2 consecutive cycles.
- **Timeout count:** starts in the cycle after `wr_start`. `ack_error` is set on the ACK_TIMEOUT-th cycle with `wr_busy` still 0.
- **Full FIFO with simultaneous pop:** the push is accepted and the level stays at DEPTH.
- **`rst` mid-transfer:** the block returns to IDLE at once and all queued data is discarded. The writer completes its current word on its own.

## Structure
- **Package `log_pkg`:**
  - `HDR_TAG` = 8'hA5.
  - State enum `feeder_state_t`.
  - `LOG_WORD_W` = 16, also shared with `sd_spi_writer`.
- **Sub-module `sample_fifo`:** synchronous FIFO with parameters DEPTH and width; ports push, pop, din, dout (show-ahead), level, full, empty.
- **Top level:** the feeder top holds only the FSM, counters and sticky flags.

## Test plan
- **Reset values:** reset, then idle for 20 cycles -> all outputs are 0 and `wr_start` never pulses.
- **Basic framing:** push 0x1234; writer model raises busy 1 cycle after start and holds it 64 cycles -> `wr_data` sequence is 0xA500, then 0x1234; next frame header is 0xA501 after 8 data words.
- **Overflow:** writer model holds busy high; push 20 samples (DEPTH=16) -> `fifo_level` = 16, `overflow` = 1; after drain, exactly the first 16 samples appear in order.
- **Push at full with pop:** FIFO full, and a push coincides with an ISSUE_DAT pop -> sample accepted, `fifo_level` stays 16, `overflow` unchanged.
- **Ack timeout:** writer model never raises busy -> `ack_error` = 1 exactly ACK_TIMEOUT cycles after `wr_start`, and the FSM returns to IDLE.
- **Counter wrap and reset mid-transfer:** run 256 frames -> header 256 is 0xA500 again. Then assert `rst` in WAIT_DONE -> the next `wr_start` is preceded by fresh framing with header 0xA500.
